pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32I pipeline.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/pipeline_ctrl_hazard_detect.sv | 27 ++
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the RV32I pipeline control slice.
//   rv32i_word        : 32-bit datapath word (addresses, data)
//   rv32i_reg         : 5-bit architectural register index
//   pipe_ctrl_state_t : sequencer state of pipeline_ctrl
package pipeline_ctrl_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare for the ID stage.
//   idex_mem_read : instruction in id_ex is a load
//   idex_rd       : destination of that load
//   ifid_rs1/rs2  : sources of the instruction in if_id
//   ifid_use_rs1/2: whether those sources are actually read
//   load_use      : instruction in if_id must wait one cycle for the load
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic     idex_mem_read,
    input  rv32i_reg idex_rd,
    input  rv32i_reg ifid_rs1,
    input  rv32i_reg ifid_rs2,
    input  logic     ifid_use_rs1,
    input  logic     ifid_use_rs2,
    output logic     load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = ifid_use_rs1 && (ifid_rs1 == idex_rd);
    assign rs2_hit  = ifid_use_rs2 && (ifid_rs2 == idex_rd);
    // x0 is never a real dependency
    assign load_use = idex_mem_read && (idex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
//   Inputs : cache handshakes (imem/dmem), id_ex/if_id register fields for
//            the load-use compare, EX-stage redirect and target.
//   Outputs: load/flush enables for PC, if_id, id_ex, ex_mem, mem_wb,
//            PC redirect select and address, fetch_kill, and a saturating
//            stall-cycle counter.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal operation; redirects taken immediately if fetch is ready
//   KILL  | redirect captured in tgt_q, waiting for the in-flight fetch to
//         | return so it can be discarded and the PC redirected
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic             dmem_resp,
    input  logic             idex_mem_read,
    input  rv32i_reg         idex_rd,
    input  rv32i_reg         ifid_rs1,
    input  rv32i_reg         ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             ex_redirect,
    input  rv32i_word        ex_target,
    output logic             pc_load,
    output logic             pc_redirect,
    output rv32i_word        redirect_addr,
    output logic             if_id_load,
    output logic             if_id_flush,
    output logic             id_ex_load,
    output logic             id_ex_flush,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             fetch_kill,
    output logic [CNT_W-1:0] stall_count
);

    pipe_ctrl_state_t state, next_state;
    rv32i_word        tgt_q, tgt_d;
    logic             dmem_stall;
    logic             imem_stall;
    logic             load_use;
    logic             stall_event;

    hazard_detect u_hazard_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_use_rs1  (ifid_use_rs1),
        .ifid_use_rs2  (ifid_use_rs2),
        .load_use      (load_use)
    );

    assign dmem_stall  = (dmem_read || dmem_write) && !dmem_resp;
    assign imem_stall  = imem_read && !imem_resp;
    assign stall_event = dmem_stall || imem_stall || load_use || (state == KILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            tgt_q <= '0;
        end else begin
            state <= next_state;
            tgt_q <= tgt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_event && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        pc_load       = 1'b0;
        pc_redirect   = 1'b0;
        redirect_addr = (state == KILL) ? tgt_q : ex_target;
        if_id_load    = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_load    = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_load   = 1'b0;
        mem_wb_load   = 1'b0;
        fetch_kill    = 1'b0;
        next_state    = state;
        tgt_d         = tgt_q;

        if (!rst) begin
            case (state)
                RUN: begin
                    if (dmem_stall) begin
                        // whole pipe freezes; an imem_resp here is dropped and refetched
                    end else if (ex_redirect && !imem_stall) begin
                        pc_load     = 1'b1;
                        pc_redirect = 1'b1;
                        if_id_load  = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_load  = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_mem_load = 1'b1;
                        mem_wb_load = 1'b1;
                    end else if (ex_redirect) begin
                        // fetch still outstanding: park the target until it returns
                        if_id_load  = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_load  = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_mem_load = 1'b1;
                        mem_wb_load = 1'b1;
                        tgt_d       = ex_target;
                        next_state  = KILL;
                    end else if (load_use) begin
                        id_ex_load  = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_mem_load = 1'b1;
                        mem_wb_load = 1'b1;
                    end else if (imem_stall) begin
                        if_id_load  = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_load  = 1'b1;
                        ex_mem_load = 1'b1;
                        mem_wb_load = 1'b1;
                    end else begin
                        pc_load     = 1'b1;
                        if_id_load  = 1'b1;
                        id_ex_load  = 1'b1;
                        ex_mem_load = 1'b1;
                        mem_wb_load = 1'b1;
                    end
                end
                KILL: begin
                    // front end only carries bubbles until the stale fetch is dropped
                    if_id_load  = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_load  = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_load = !dmem_stall;
                    mem_wb_load = !dmem_stall;
                    if (imem_resp) begin
                        fetch_kill  = 1'b1;
                        pc_load     = 1'b1;
                        pc_redirect = 1'b1;
                        next_state  = RUN;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

endmodule
